// File: rtl/pipeline_control_unit_pkg.sv
// rtl/pipeline_control_unit_pkg.sv - shared pipeline control types, FSM encoding and register constants
package pipeline_control_unit_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd2;

    typedef logic [1:0] pcu_state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_DEFAULT = 8'b1111_0000;
    localparam pipe_ctrl_t CTRL_FREEZE  = 8'b0000_0001;

endpackage

// File: rtl/pipeline_control_unit_hazard_compare.sv
// rtl/pipeline_control_unit_hazard_compare.sv - load-use hazard detect between EX load and ID sources
module hazard_compare
    import pipeline_control_unit_pkg::*;
(
    input  logic       id_ex_mem_read,
    input  logic [4:0] id_ex_rd,
    input  logic [4:0] if_id_rn1,
    input  logic [4:0] if_id_rm2,
    output logic       hz
);

    // XZR reads as zero, so a load targeting it never feeds a consumer
    assign hz = id_ex_mem_read && (id_ex_rd != XZR_IDX) &&
                ((id_ex_rd == if_id_rn1) || (id_ex_rd == if_id_rm2));

endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stall/flush control with data-memory wait FSM and event counters
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic [4:0]       IF_ID_RegisterRn1,
    input  logic [4:0]       IF_ID_RegisterRm2,
    input  logic             EX_MEM_BranchTaken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

    pcu_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       hz;
    logic       dmem_stall;
    logic [WAIT_W-1:0] wait_inc;
    pipe_ctrl_t run_ctrl;
    logic       run_branch;
    pipe_ctrl_t ctrl;
    logic       branch_flush;

    hazard_compare u_hazard_compare (
        .id_ex_mem_read (ID_EX_MemRead),
        .id_ex_rd       (ID_EX_RegisterRd),
        .if_id_rn1      (IF_ID_RegisterRn1),
        .if_id_rm2      (IF_ID_RegisterRm2),
        .hz             (hz)
    );

    assign dmem_stall = dmem_req && !dmem_ready;
    assign wait_inc   = wait_cnt_q + WAIT_ONE;

    // Lower-priority events resolved assuming the data memory is not stalling
    always_comb begin
        run_ctrl   = CTRL_DEFAULT;
        run_branch = 1'b0;
        if (EX_MEM_BranchTaken) begin
            run_ctrl.if_id_flush  = 1'b1;
            run_ctrl.id_ex_flush  = 1'b1;
            run_ctrl.ex_mem_flush = 1'b1;
            run_branch            = 1'b1;
        end else if (hz) begin
            run_ctrl.pc_write    = 1'b0;
            run_ctrl.if_id_write = 1'b0;
            run_ctrl.id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            run_ctrl.pc_write    = 1'b0;
            run_ctrl.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        ctrl          = CTRL_DEFAULT;
        branch_flush  = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_stall) begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = WAIT_ONE;
                    if (TIMEOUT_VAL <= WAIT_ONE) begin
                        state_d       = ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        state_d = ST_MEMWAIT;
                    end
                end else begin
                    ctrl         = run_ctrl;
                    branch_flush = run_branch;
                    wait_cnt_d   = '0;
                end
            end
            ST_MEMWAIT: begin
                if (!dmem_ready) begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_inc;
                    if (wait_inc >= TIMEOUT_VAL) begin
                        state_d       = ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    ctrl         = run_ctrl;
                    branch_flush = run_branch;
                    state_d      = ST_RUN;
                    wait_cnt_d   = '0;
                end
            end
            ST_ERROR: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ctrl.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign PCWrite       = ctrl.pc_write;
    assign IF_ID_Write   = ctrl.if_id_write;
    assign ID_EX_Write   = ctrl.id_ex_write;
    assign EX_MEM_Write  = ctrl.ex_mem_write;
    assign IF_ID_Flush   = ctrl.if_id_flush;
    assign ID_EX_Flush   = ctrl.id_ex_flush;
    assign EX_MEM_Flush  = ctrl.ex_mem_flush;
    assign MEM_WB_Bubble = ctrl.mem_wb_bubble;
    assign mem_timeout   = mem_timeout_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule
